// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one byte-serial transmitter between NUM_SRC message sources.
// Whole messages are granted round-robin. Each grant can be preceded by a tag
// byte {HDR_PREFIX, src_idx}. A grant is released early, with a drop_evt pulse,
// when MAX_BURST payload bytes have gone out without req_last, or when the
// owner holds valid low for STALL_TIMEOUT cycles in the middle of a message.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-source byte available
//   req_data     per-source byte, source i at [8i+7:8i]
//   req_last     per-source last-byte-of-message flag
//   req_ready    per-source accept (only the granted source, only in FETCH)
//   tx_start     one-cycle start pulse to the transmitter
//   tx_data      byte to transmit, held from tx_start until tx_busy falls
//   tx_busy      transmitter busy
//   grant        one-hot owner, 0 when idle
//   active       message in progress
//   drop_evt     one-cycle pulse on forced release
module uart_tx_scheduler #(
    parameter int         NUM_SRC       = 4,
    parameter int         HEADER_EN     = 1,
    parameter logic [4:0] HDR_PREFIX    = 5'b10100,
    parameter int         MAX_BURST     = 64,
    parameter int         STALL_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   req_valid,
    input  logic [8*NUM_SRC-1:0] req_data,
    input  logic [NUM_SRC-1:0]   req_last,
    output logic [NUM_SRC-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 active,
    output logic                 drop_evt
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WAIT_HI, S_WAIT_LO, S_FETCH, S_RELEASE
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_idx;
    logic [NUM_SRC-1:0]  r_grant;
    logic                r_active;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_drop;
    logic                r_last;
    logic [7:0]          r_burst;
    logic [15:0]         r_stall;

    logic                w_found;
    logic [PW-1:0]       w_win;
    logic [PW-1:0]       w_cand;
    int                  w_sum;
    logic                w_gvalid;
    logic                w_glast;
    logic [7:0]          w_gdata;
    logic [7:0]          w_tag;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_sum   = 0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NUM_SRC) w_sum = w_sum - NUM_SRC;
            w_cand = PW'(w_sum);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Owner's byte/flags via the one-hot grant; other sources are don't-care.
    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant[i]) w_gdata = req_data[8*i +: 8];
        end
    end

    assign w_gvalid  = |(req_valid & r_grant);
    assign w_glast   = |(req_last & r_grant);
    assign w_tag     = {HDR_PREFIX, 3'(r_idx)};
    assign req_ready = (r_state == S_FETCH) ? r_grant : '0;

    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign grant     = r_grant;
    assign active    = r_active;
    assign drop_evt  = r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= PW'(NUM_SRC - 1);
            r_idx      <= '0;
            r_grant    <= '0;
            r_active   <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_drop     <= 1'b0;
            r_last     <= 1'b0;
            r_burst    <= '0;
            r_stall    <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_drop     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The transmitter is not reset with us, so a byte from
                    // before our reset may still be on the wire.
                    if (w_found && !tx_busy) begin
                        r_grant  <= {{(NUM_SRC-1){1'b0}}, 1'b1} << w_win;
                        r_idx    <= w_win;
                        r_ptr    <= w_win;
                        r_active <= 1'b1;
                        r_state  <= (HEADER_EN != 0) ? S_HDR : S_FETCH;
                    end
                end
                S_HDR: begin
                    r_tx_data  <= w_tag;
                    r_tx_start <= 1'b1;
                    r_state    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) r_state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (r_last || (r_burst == 8'(MAX_BURST))) begin
                            r_state <= S_RELEASE;
                            r_drop  <= !r_last;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_gvalid) begin
                        r_tx_data  <= w_gdata;
                        r_last     <= w_glast;
                        r_burst    <= r_burst + 8'd1;
                        r_stall    <= '0;
                        r_tx_start <= 1'b1;
                        r_state    <= S_WAIT_HI;
                    end else if (r_stall == 16'(STALL_TIMEOUT - 1)) begin
                        r_state <= S_RELEASE;
                        r_drop  <= 1'b1;
                    end else begin
                        r_stall <= r_stall + 16'd1;
                    end
                end
                S_RELEASE: begin
                    r_grant  <= '0;
                    r_active <= 1'b0;
                    r_burst  <= '0;
                    r_stall  <= '0;
                    r_last   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: source queues, a transmitter model that
// raises busy one cycle after start, a stream monitor, and a message-level
// round-robin reference model.
module tb_uart_tx_scheduler;
    localparam int NS    = 4;
    localparam int MB    = 4;
    localparam int ST    = 16;
    localparam int LIMIT = 5000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NS-1:0]   req_valid = '0;
    logic [8*NS-1:0] req_data = '0;
    logic [NS-1:0]   req_last = '0;
    logic [NS-1:0]   req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic [NS-1:0]   grant;
    logic            active;
    logic            drop_evt;

    uart_tx_scheduler #(
        .NUM_SRC(NS), .HEADER_EN(1), .HDR_PREFIX(5'b10100),
        .MAX_BURST(MB), .STALL_TIMEOUT(ST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant), .active(active),
        .drop_evt(drop_evt)
    );

    always #5 clk = ~clk;

    // Transmitter: busy for tx_len cycles starting the cycle after start.
    int tx_len = 20;
    int bcnt = 0;
    always @(posedge clk) begin
        if (tx_start) bcnt <= tx_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0);

    typedef struct {
        int src;
        int len;
        int exp_tx;
        int exp_drop;
    } vec_t;

    int            nchk = 0;
    int            nerr = 0;
    logic [8:0]    srcq [NS][$];
    logic [8:0]    mq   [NS][$];
    logic [NS-1:0] fire = '0;
    logic [7:0]    got  [$];
    logic [NS-1:0] gotg [$];
    int            ndrop = 0;
    logic          holding = 1'b0, prev_busy = 1'b0, prev_start = 1'b0, prev_drop = 1'b0;
    logic [7:0]    held = '0;
    logic [7:0]    eb [$];
    logic [NS-1:0] eg [$];
    int            ed = 0;
    vec_t          vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] tag(input int s);
        return {5'b10100, 3'(s)};
    endfunction

    function automatic logic [NS-1:0] onehot(input int s);
        logic [NS-1:0] g;
        g = '0;
        g[s] = 1'b1;
        return g;
    endfunction

    task automatic monitor();
        if (!rst_n) begin
            holding = 1'b0; prev_busy = 1'b0; prev_start = 1'b0; prev_drop = 1'b0;
            return;
        end
        if (tx_start) begin
            chk("start_while_busy", 32'(tx_busy), 32'd0);
            chk("start_width", 32'(prev_start), 32'd0);
            got.push_back(tx_data);
            gotg.push_back(grant);
            held = tx_data;
            holding = 1'b1;
        end else if (holding) begin
            chk("tx_data_hold", 32'(tx_data), 32'(held));
            if (prev_busy && !tx_busy) holding = 1'b0;
        end
        if (drop_evt) begin
            ndrop++;
            chk("drop_width", 32'(prev_drop), 32'd0);
        end
        prev_busy = tx_busy; prev_start = tx_start; prev_drop = drop_evt;
    endtask

    // Sources: a byte leaves its queue on the edge after valid&ready was seen.
    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < NS; i++) begin
            if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0) begin
                h = srcq[i][0];
                req_valid[i] = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i] = h[8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
        fire = req_valid & req_ready;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        drive();
    endtask

    task automatic push_byte(input int s, input logic [7:0] d, input logic l, input bit to_model);
        srcq[s].push_back({l, d});
        if (to_model) mq[s].push_back({l, d});
    endtask

    task automatic push_msg(input int s, input int len);
        for (int j = 0; j < len; j++) push_byte(s, 8'($urandom), (j == len - 1), 1'b1);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            srcq[i].delete();
            mq[i].delete();
        end
        got.delete(); gotg.delete(); eb.delete(); eg.delete();
        ndrop = 0; ed = 0; fire = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic bit is_done();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NS; i++) if (srcq[i].size() != 0) e = 1'b0;
        return e && !active && !tx_busy && !tx_start;
    endfunction

    task automatic wait_done(input string nm);
        int c;
        c = 0;
        while (!is_done() && c < LIMIT) begin
            tick();
            c++;
        end
        chk({nm, "_done"}, 32'(is_done()), 32'd1);
    endtask

    // Reference: whole messages, round-robin over non-empty queues starting
    // after the previous owner; a grant carries at most MB payload bytes.
    task automatic run_model();
        int p, w, n;
        bit found, fin;
        logic [8:0] b;
        eb.delete(); eg.delete(); ed = 0;
        p = NS - 1;
        while (1) begin
            found = 1'b0; w = 0;
            for (int k = 1; k <= NS; k++) begin
                if (!found && mq[(p + k) % NS].size() > 0) begin
                    found = 1'b1;
                    w = (p + k) % NS;
                end
            end
            if (!found) break;
            p = w;
            eb.push_back(tag(w)); eg.push_back(onehot(w));
            n = 0; fin = 1'b0;
            while (!fin && mq[w].size() > 0) begin
                b = mq[w].pop_front();
                eb.push_back(b[7:0]); eg.push_back(onehot(w));
                n++;
                if (b[8]) fin = 1'b1;
                else if (n == MB) begin
                    fin = 1'b1;
                    ed++;
                end
            end
        end
    endtask

    task automatic cmp_stream(input string nm);
        chk({nm, "_count"}, 32'(got.size()), 32'(eb.size()));
        for (int i = 0; i < eb.size(); i++) begin
            if (i < got.size()) begin
                chk($sformatf("%s_byte%0d", nm, i), 32'(got[i]), 32'(eb[i]));
                chk($sformatf("%s_grant%0d", nm, i), 32'(gotg[i]), 32'(eg[i]));
            end
        end
        chk({nm, "_drops"}, 32'(ndrop), 32'(ed));
    endtask

    initial begin
        int c, n, nm;

        vt[0] = '{1, 2, 3, 0};
        vt[1] = '{2, 6, 8, 1};
        vt[2] = '{0, 1, 2, 0};
        vt[3] = '{3, 4, 5, 0};
        vt[4] = '{3, 5, 7, 1};
        vt[5] = '{2, 8, 10, 1};
        vt[6] = '{1, 9, 12, 2};

        // Reset state
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_drop", 32'(drop_evt), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single source 1, two-byte message
        do_reset();
        push_byte(1, 8'h11, 1'b0, 1'b0);
        push_byte(1, 8'h22, 1'b1, 1'b0);
        wait_done("single");
        eb.push_back(8'hA1); eb.push_back(8'h11); eb.push_back(8'h22);
        for (int i = 0; i < 3; i++) eg.push_back(4'b0010);
        ed = 0;
        cmp_stream("single");
        chk("single_grant_idle", 32'(grant), 32'd0);

        // Table of single-source messages around the burst limit
        for (int v = 0; v < 7; v++) begin
            do_reset();
            push_msg(vt[v].src, vt[v].len);
            wait_done($sformatf("vec%0d", v));
            run_model();
            cmp_stream($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_ntx", v), 32'(got.size()), 32'(vt[v].exp_tx));
            chk($sformatf("vec%0d_ndrop", v), 32'(ndrop), 32'(vt[v].exp_drop));
        end

        // All four sources continuously valid, two 2-byte messages each
        do_reset();
        for (int r = 0; r < 2; r++) for (int s = 0; s < NS; s++) push_msg(s, 2);
        wait_done("rr");
        run_model();
        cmp_stream("rr");
        if (got.size() >= 13) begin
            chk("rr_hdr0", 32'(got[0]), 32'hA0);
            chk("rr_hdr1", 32'(got[3]), 32'hA1);
            chk("rr_hdr2", 32'(got[6]), 32'hA2);
            chk("rr_hdr3", 32'(got[9]), 32'hA3);
            chk("rr_hdr4", 32'(got[12]), 32'hA0);
        end else begin
            chk("rr_len", 32'(got.size()), 32'd24);
        end

        // Stall: source 0 sends one byte without last, then goes quiet
        do_reset();
        push_byte(0, 8'h55, 1'b0, 1'b0);
        c = 0;
        while (srcq[0].size() > 0 && c < LIMIT) begin tick(); c++; end
        chk("stall_accept", 32'(srcq[0].size()), 32'd0);
        push_byte(3, 8'h3C, 1'b1, 1'b0);
        c = 0;
        while (!req_ready[0] && c < LIMIT) begin tick(); c++; end
        chk("stall_fetch_seen", 32'(req_ready[0]), 32'd1);
        n = 0;
        while (req_ready[0] && n < 100) begin tick(); n++; end
        chk("stall_cycles", 32'(n), 32'(ST));
        chk("stall_drop", 32'(drop_evt), 32'd1);
        wait_done("stall");
        eb.push_back(8'hA0); eb.push_back(8'h55); eb.push_back(8'hA3); eb.push_back(8'h3C);
        eg.push_back(4'b0001); eg.push_back(4'b0001); eg.push_back(4'b1000); eg.push_back(4'b1000);
        ed = 1;
        cmp_stream("stall");

        // Reset while a byte is on the wire
        do_reset();
        push_msg(2, 3);
        c = 0;
        while (!(got.size() >= 2 && tx_busy) && c < LIMIT) begin tick(); c++; end
        chk("midrst_inflight", 32'(tx_busy), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_start", 32'(tx_start), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_active", 32'(active), 32'd0);
        clear_all();
        push_byte(0, 8'h77, 1'b1, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        c = 0;
        while (got.size() == 0 && c < LIMIT) begin tick(); c++; end
        if (got.size() > 0) chk("midrst_first_hdr", 32'(got[0]), 32'hA0);
        else chk("midrst_first_start", 32'(got.size()), 32'd1);
        wait_done("midrst");
        run_model();
        cmp_stream("midrst");

        // Acceptance-to-start latency and tx_data hold
        do_reset();
        push_byte(1, 8'h5A, 1'b1, 1'b1);
        c = 0;
        while (!(req_valid[1] && req_ready[1]) && c < LIMIT) begin tick(); c++; end
        chk("lat_accept_seen", 32'(req_ready[1]), 32'd1);
        chk("lat_no_early_start", 32'(tx_start), 32'd0);
        tick();
        chk("lat_start", 32'(tx_start), 32'd1);
        chk("lat_data", 32'(tx_data), 32'h5A);
        wait_done("lat");
        run_model();
        cmp_stream("lat");

        // Randomized message mixes against the reference model
        for (int r = 0; r < 4; r++) begin
            tx_len = $urandom_range(1, 5);
            do_reset();
            for (int s = 0; s < NS; s++) begin
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) push_msg(s, $urandom_range(1, 9));
            end
            wait_done($sformatf("rnd%0d", r));
            run_model();
            cmp_stream($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
